instr_encoder_loader: RTL and testbench

//  Streaming MIPS instruction encoder and program loader: the inverse of the control-unit decoder.
//  - Accepts mnemonic-plus-field requests over a valid/ready handshake.
//  - Packs each into a 32-bit word (opcode/funct set matching the decoder).
//  - Writes the words into instruction memory at consecutive word addresses.

---
 rtl/instr_enc_pkg.sv | 51 +++++
 rtl/instr_field_packer.sv | 36 +++
 rtl/instr_encoder_loader.sv | 199 +++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared encoding constants for the MIPS instruction encoder/loader.
// Opcode and funct values match the control-unit decoder.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_SLT  = 4'd2,
    MN_MUL  = 4'd3,
    MN_AND  = 4'd4,
    MN_OR   = 4'd5,
    MN_LW   = 4'd6,
    MN_SW   = 4'd7,
    MN_ADDI = 4'd8,
    MN_BEQ  = 4'd9,
    MN_J    = 4'd10
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011100;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FULL = 3'd2,
    ST_PAD  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational mnemonic + fields -> 32-bit MIPS word, with an illegal flag
// for mnemonic codes 11..15 (word forced to zero in that case).
module instr_field_packer
  import instr_enc_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Encode one request.
  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (mnem)
      MN_ADD:  word = pack_r(rs, rt, rd, FN_ADD);
      MN_SUB:  word = pack_r(rs, rt, rd, FN_SUB);
      MN_SLT:  word = pack_r(rs, rt, rd, FN_SLT);
      MN_MUL:  word = pack_r(rs, rt, rd, FN_MUL);
      MN_AND:  word = pack_r(rs, rt, rd, FN_AND);
      MN_OR:   word = pack_r(rs, rt, rd, FN_OR);
      MN_LW:   word = pack_i(OP_LW, rs, rt, imm);
      MN_SW:   word = pack_i(OP_SW, rs, rt, imm);
      MN_ADDI: word = pack_i(OP_ADDI, rs, rt, imm);
      MN_BEQ:  word = pack_i(OP_BEQ, rs, rt, imm);
      MN_J:    word = {OP_J, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streaming MIPS encoder / imem program loader. Optional zero-padding of the
// remaining memory after the last instruction is enabled by INSTR_ENC_NOP_PAD_EN.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int Instruction_Width = 32,
  parameter int ADDR_WIDTH        = 6,
  parameter int BASE_ADDR         = 0
)(
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [3:0]                   req_mnem,
  input  logic [4:0]                   req_rs,
  input  logic [4:0]                   req_rt,
  input  logic [4:0]                   req_rd,
  input  logic [15:0]                  req_imm,
  input  logic [25:0]                  req_target,
  input  logic                         req_last,
  output logic                         imem_we,
  output logic [ADDR_WIDTH-1:0]        imem_addr,
  output logic [Instruction_Width-1:0] imem_wdata,
  output logic                         busy,
  output logic                         load_done,
  output logic                         err_illegal,
  output logic                         err_full,
  output logic [ADDR_WIDTH:0]          count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  state_e                         state_r, state_s;
  logic [ADDR_WIDTH-1:0]          addr_r, addr_s, waddr_r, waddr_s;
  logic [ADDR_WIDTH:0]            count_r, count_s;
  logic [Instruction_Width-1:0]   wdata_r, wdata_s;
  logic                           exhausted_r, exhausted_s, drain_r, drain_s;
  logic                           we_r, we_s, ready_r, ready_s, busy_r, busy_s, done_r, done_s;
  logic                           err_ill_r, err_ill_s, err_full_r, err_full_s;
  logic [31:0]                    pk_word_s;
  logic                           pk_illegal_s, accept_s;

  instr_field_packer u_packer (
    .mnem    (req_mnem),
    .rs      (req_rs),
    .rt      (req_rt),
    .rd      (req_rd),
    .imm     (req_imm),
    .target  (req_target),
    .word    (pk_word_s),
    .illegal (pk_illegal_s)
  );

  assign accept_s = req_valid & ready_r;

  // Next-state and next-output logic; exhausted marks that the top word has been written.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    count_s     = count_r;
    exhausted_s = exhausted_r;
    drain_s     = drain_r;
    we_s        = 1'b0;
    waddr_s     = waddr_r;
    wdata_s     = wdata_r;
    done_s      = 1'b0;
    err_ill_s   = err_ill_r;
    err_full_s  = err_full_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s     = ST_LOAD;
          addr_s      = BASE;
          count_s     = '0;
          exhausted_s = 1'b0;
          drain_s     = 1'b0;
          err_ill_s   = 1'b0;
          err_full_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (drain_r) begin
          // The req_last word is being written this cycle.
          drain_s = 1'b0;
`ifdef INSTR_ENC_NOP_PAD_EN
          if (exhausted_r) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_PAD;
          end
`else
          state_s = ST_DONE;
          done_s  = 1'b1;
`endif
        end else if (accept_s) begin
          if (pk_illegal_s) begin
            err_ill_s = 1'b1;
          end else begin
            we_s    = 1'b1;
            waddr_s = addr_r;
            wdata_s = Instruction_Width'(pk_word_s);
            count_s = count_r + (ADDR_WIDTH+1)'(1);
            if (addr_r == LAST_ADDR) begin
              exhausted_s = 1'b1;
            end else begin
              addr_s = addr_r + ADDR_WIDTH'(1);
            end
          end
          if (req_last) begin
            drain_s = 1'b1;
          end else if (!pk_illegal_s && (addr_r == LAST_ADDR)) begin
            state_s = ST_FULL;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_FULL: begin
        if (req_valid) begin
          err_full_s = 1'b1;
          state_s    = ST_DONE;
          done_s     = 1'b1;
        end else begin
          state_s = ST_FULL;
        end
      end
      ST_PAD: begin
        if (exhausted_r) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          we_s    = 1'b1;
          waddr_s = addr_r;
          wdata_s = '0;
          count_s = count_r + (ADDR_WIDTH+1)'(1);
          if (addr_r == LAST_ADDR) begin
            exhausted_s = 1'b1;
          end else begin
            addr_s = addr_r + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_s = ST_IDLE;
    endcase
    ready_s = (state_s == ST_LOAD) && !drain_s;
    busy_s  = (state_s == ST_LOAD) || (state_s == ST_FULL) || (state_s == ST_PAD);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      addr_r      <= BASE;
      count_r     <= '0;
      exhausted_r <= 1'b0;
      drain_r     <= 1'b0;
      we_r        <= 1'b0;
      waddr_r     <= '0;
      wdata_r     <= '0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_ill_r   <= 1'b0;
      err_full_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      count_r     <= count_s;
      exhausted_r <= exhausted_s;
      drain_r     <= drain_s;
      we_r        <= we_s;
      waddr_r     <= waddr_s;
      wdata_r     <= wdata_s;
      ready_r     <= ready_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_ill_r   <= err_ill_s;
      err_full_r  <= err_full_s;
    end
  end

  assign req_ready   = ready_r;
  assign imem_we     = we_r;
  assign imem_addr   = waddr_r;
  assign imem_wdata  = wdata_r;
  assign busy        = busy_r;
  assign load_done   = done_r;
  assign err_illegal = err_ill_r;
  assign err_full    = err_full_r;
  assign count       = count_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a 64-word instance for encoding and
// program flow, and a 4-word instance for the full/priority/reset cases.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, valid0 = 1'b0, valid1 = 1'b0;
  logic [3:0]  mnem = 4'd0;
  logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0;
  logic [15:0] imm = 16'd0;
  logic [25:0] tgt = 26'd0;
  logic        last = 1'b0;

  logic        rdy0, we0, busy0, done0, eill0, efull0;
  logic [5:0]  addr0;
  logic [31:0] wd0;
  logic [6:0]  cnt0;
  logic        rdy1, we1, busy1, done1, eill1, efull1;
  logic [1:0]  addr1;
  logic [31:0] wd1;
  logic [2:0]  cnt1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.Instruction_Width(32), .ADDR_WIDTH(6), .BASE_ADDR(0)) u0 (
    .CLK(clk), .RST(rst_n), .start(start0), .req_valid(valid0), .req_ready(rdy0),
    .req_mnem(mnem), .req_rs(rs), .req_rt(rt), .req_rd(rd), .req_imm(imm),
    .req_target(tgt), .req_last(last), .imem_we(we0), .imem_addr(addr0),
    .imem_wdata(wd0), .busy(busy0), .load_done(done0), .err_illegal(eill0),
    .err_full(efull0), .count(cnt0)
  );

  instr_encoder_loader #(.Instruction_Width(32), .ADDR_WIDTH(2), .BASE_ADDR(0)) u1 (
    .CLK(clk), .RST(rst_n), .start(start1), .req_valid(valid1), .req_ready(rdy1),
    .req_mnem(mnem), .req_rs(rs), .req_rt(rt), .req_rd(rd), .req_imm(imm),
    .req_target(tgt), .req_last(last), .imem_we(we1), .imem_addr(addr1),
    .imem_wdata(wd1), .busy(busy1), .load_done(done1), .err_illegal(eill1),
    .err_full(efull1), .count(cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg,
                         input logic l);
    mnem = m; rs = s; rt = t; rd = d; imm = im; tgt = tg; last = l;
  endtask

  initial begin
    // Reset values
    tick(); tick();
    chk("rst_we", we0, 0);       chk("rst_ready", rdy0, 0);  chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);   chk("rst_eill", eill0, 0);  chk("rst_efull", efull0, 0);
    chk("rst_count", cnt0, 0);   chk("rst_addr", addr0, 0);  chk("rst_wdata", wd0, 0);
    rst_n = 1'b1;
    tick();

    // 1: ADD r3 = r1 + r2
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("start_ready", rdy0, 1); chk("start_busy", busy0, 1);
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0); valid0 = 1'b1; tick();
    chk("add_we", we0, 1); chk("add_addr", addr0, 0); chk("add_wdata", wd0, 32'h00221820);
    chk("add_count", cnt0, 1);

    // 2: back-to-back LW / SW / BEQ
    set_req(4'd6, 5'd1, 5'd2, 5'd0, 16'd4, 26'd0, 1'b0); tick();
    chk("lw_we", we0, 1); chk("lw_addr", addr0, 1); chk("lw_wdata", wd0, 32'h8C220004);
    set_req(4'd7, 5'd0, 5'd2, 5'd0, 16'd8, 26'd0, 1'b0); tick();
    chk("sw_we", we0, 1); chk("sw_addr", addr0, 2); chk("sw_wdata", wd0, 32'hAC020008);
    set_req(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0); tick();
    chk("beq_we", we0, 1); chk("beq_addr", addr0, 3); chk("beq_wdata", wd0, 32'h1022FFFF);

    // 4: illegal mnemonic is swallowed
    set_req(4'd12, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0); tick();
    chk("ill_we", we0, 0); chk("ill_flag", eill0, 1); chk("ill_count", cnt0, 4);
    chk("ill_ready", rdy0, 1);

    // 3: J with req_last lands at the unchanged address
    set_req(4'd10, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1); tick();
    valid0 = 1'b0;
    chk("j_we", we0, 1); chk("j_addr", addr0, 4); chk("j_wdata", wd0, 32'h08000010);
    chk("j_ready", rdy0, 0); chk("j_done_early", done0, 0);
`ifdef INSTR_ENC_NOP_PAD_EN
    begin
      int n = 0;
      while (!done0 && n < 100) begin tick(); n++; end
      chk("pad_done_seen", done0, 1); chk("pad_count", cnt0, 64); chk("pad_busy", busy0, 0);
    end
`else
    tick();
    chk("j_done", done0, 1); chk("j_busy", busy0, 0); chk("j_count", cnt0, 5);
`endif
    tick();
    chk("done_pulse_end", done0, 0); chk("ill_sticky", eill0, 1);

    // restart clears sticky errors and count
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("restart_eill", eill0, 0); chk("restart_count", cnt0, 0); chk("restart_ready", rdy0, 1);

    // 5: four-word memory fills, fifth request hits FULL
    start1 = 1'b1; tick(); start1 = 1'b0;
    valid1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(4'd8, 5'd1, 5'd2, 5'd0, 16'(i), 26'd0, 1'b0); tick();
      chk("fill_addr", addr1, 64'(i)); chk("fill_wdata", wd1, 64'(32'h20220000 + i));
    end
    chk("full_ready", rdy1, 0); chk("full_busy", busy1, 1);
    tick();
    valid1 = 1'b0;
    chk("full_err", efull1, 1); chk("full_done", done1, 1); chk("full_we", we1, 0);
    chk("full_count", cnt1, 4); chk("full_idle", busy1, 0);

    // req_last on the final word: DONE wins over FULL
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("restart_efull", efull1, 0);
    valid1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(4'd8, 5'd3, 5'd4, 5'd0, 16'h0100, 26'd0, (i == 3) ? 1'b1 : 1'b0); tick();
    end
    chk("prio_addr", addr1, 3); chk("prio_wdata", wd1, 32'h20640100); chk("prio_ready", rdy1, 0);
    tick();
    valid1 = 1'b0;
    chk("prio_done", done1, 1); chk("prio_efull", efull1, 0); chk("prio_count", cnt1, 4);

`ifdef INSTR_ENC_NOP_PAD_EN
    // 6: last at addr 1 pads address 2 with zero; reset lands mid-pad
    start1 = 1'b1; tick(); start1 = 1'b0;
    valid1 = 1'b1;
    set_req(4'd8, 5'd1, 5'd1, 5'd0, 16'd7, 26'd0, 1'b0); tick();
    set_req(4'd8, 5'd1, 5'd1, 5'd0, 16'd9, 26'd0, 1'b1); tick();
    valid1 = 1'b0;
    chk("padl_addr", addr1, 1);
    tick();
    chk("padl_gap", we1, 0);
    tick();
    chk("pad_we", we1, 1); chk("pad_addr", addr1, 2); chk("pad_wdata", wd1, 0);
    #2 rst_n = 1'b0;
    #1;
`else
    // reset mid-load discards the pending write
    start1 = 1'b1; tick(); start1 = 1'b0;
    valid1 = 1'b1;
    set_req(4'd5, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0); tick();
    chk("pre_rst_we", we1, 1); chk("pre_rst_wdata", wd1, 32'h00221825);
    #2 rst_n = 1'b0;
    #1;
    valid1 = 1'b0;
`endif
    chk("arst_we", we1, 0);     chk("arst_ready", rdy1, 0); chk("arst_busy", busy1, 0);
    chk("arst_count", cnt1, 0); chk("arst_addr", addr1, 0); chk("arst_wdata", wd1, 0);
    chk("arst_u0_busy", busy0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
